mem_req_unit: RTL

//  MEM-stage load/store initiator: the requester side of the data-memory interface.

---
 rtl/mem_req_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_req_unit.sv
// MEM-stage load/store initiator: req/gnt/rvalid handshake towards data memory.
// Optional MEM_TRACE_EN prints completed stores. Ops: wd=0 hf=1 bt=2 uhf=3 ubt=4.
module mem_req_unit #(
    parameter logic [31:0] ADDR_MASK = 32'h0000_3FFF,
    parameter logic [7:0]  TO_CYC    = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] pc_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        timeout_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [2:0] OP_HF  = 3'd1;
    localparam logic [2:0] OP_BT  = 3'd2;
    localparam logic [2:0] OP_UHF = 3'd3;
    localparam logic [2:0] OP_UBT = 3'd4;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      state, state_nxt;
    logic        take, tmo;
    logic        we_q, mis_q, to_q;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [31:2] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q, rdata_q;
    logic [8:0]  cnt, cnt_inc;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, lane, ext;
    logic        mis_new;

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = wdata_i;
        mis_new   = |addr_i[1:0];
        case (op_i)
            OP_HF, OP_UHF: begin
                be_new    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_new = {2{wdata_i[15:0]}};
                mis_new   = addr_i[0];
            end
            OP_BT, OP_UBT: begin
                be_new    = 4'b0001 << addr_i[1:0];
                wdata_new = {4{wdata_i[7:0]}};
                mis_new   = 1'b0;
            end
            default: ;
        endcase
    end

    assign lane = mem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        case (op_q)
            OP_HF:   ext = {{16{lane[15]}}, lane[15:0]};
            OP_BT:   ext = {{24{lane[7]}}, lane[7:0]};
            OP_UHF:  ext = {16'h0000, lane[15:0]};
            OP_UBT:  ext = {24'h000000, lane[7:0]};
            default: ext = lane;
        endcase
    end

    // Counter is one bit wider than TO_CYC so a grant on the expiry edge cannot wrap it.
    assign cnt_inc = cnt + 9'd1;

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: if (req_i) state_nxt = mis_new ? DONE : REQ;
            REQ: begin
                if (mem_gnt_i && mem_rvalid_i) begin
                    state_nxt = DONE;
                    take      = 1'b1;
                end else if (mem_gnt_i) begin
                    state_nxt = RESP;
                end else if (cnt_inc >= {1'b0, TO_CYC}) begin
                    state_nxt = DONE;
                    tmo       = 1'b1;
                end
            end
            RESP: begin
                if (mem_rvalid_i) begin
                    state_nxt = DONE;
                    take      = 1'b1;
                end else if (cnt_inc >= {1'b0, TO_CYC}) begin
                    state_nxt = DONE;
                    tmo       = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
            op_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (req_i) begin
                    // Misaligned accesses never reach memory, so their payload stays zero.
                    we_q    <= we_i & ~mis_new;
                    mis_q   <= mis_new;
                    to_q    <= 1'b0;
                    op_q    <= op_i;
                    off_q   <= addr_i[1:0];
                    addr_q  <= mis_new ? '0 : (addr_i[31:2] & ADDR_MASK[31:2]);
                    be_q    <= mis_new ? '0 : be_new;
                    wdata_q <= mis_new ? '0 : wdata_new;
                    rdata_q <= '0;
                    cnt     <= '0;
                end
                REQ, RESP: begin
                    cnt <= cnt_inc;
                    if (take) rdata_q <= we_q ? '0 : ext;
                    if (tmo)  to_q    <= 1'b1;
                end
                DONE: begin
                    we_q    <= 1'b0;
                    mis_q   <= 1'b0;
                    to_q    <= 1'b0;
                    addr_q  <= '0;
                    be_q    <= '0;
                    wdata_q <= '0;
                    rdata_q <= '0;
                    cnt     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign done_o      = (state == DONE);
    assign stall_o     = req_i & ~done_o;
    assign misalign_o  = done_o & mis_q;
    assign timeout_o   = done_o & to_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = (state == REQ);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = {addr_q, 2'b00};
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

`ifdef MEM_TRACE_EN
    logic [31:0] pc_q;
    logic [31:0] trace_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      pc_q <= '0;
        else if (state == IDLE && req_i) pc_q <= pc_i;
    end

    always_comb begin
        trace_wdata = '0;
        for (int unsigned i = 0; i < 4; i++)
            if (be_q[i]) trace_wdata[8*i +: 8] = wdata_q[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (done_o && we_q && !mis_q && !to_q)
            $display("@%h: *%h <= %h", pc_q, mem_addr_o, trace_wdata);
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc_i;
`endif

endmodule
